// File: rtl/urv_irq_ctrl.sv
// rtl/urv_irq_ctrl.sv - interrupt/exception CSR block with edge/level irq lines and trap handshake
module urv_irq_ctrl #(
   parameter int unsigned g_num_irqs      = 4,
   parameter logic [15:0] g_irq_edge_mask = 16'h0000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  x_stall_i,
   input  logic                  x_kill_i,
   input  logic                  d_is_csr_i,
   input  logic                  d_is_mret_i,
   input  logic [11:0]           d_csr_sel_i,
   input  logic [31:0]           x_csr_write_value_i,
   input  logic [g_num_irqs-1:0] irq_i,
   input  logic                  exp_tick_i,
   input  logic                  exp_sync_i,
   input  logic [3:0]            exp_sync_cause_i,
   input  logic [31:0]           x_exception_pc_i,
   input  logic                  x_trap_ack_i,
   output logic                  irq_req_o,
   output logic [4:0]            irq_cause_o,
   output logic [31:0]           x_exception_pc_o,
   output logic [31:0]           csr_mstatus_o,
   output logic [31:0]           csr_mie_o,
   output logic [31:0]           csr_mip_o,
   output logic [31:0]           csr_mepc_o,
   output logic [31:0]           csr_mcause_o
);

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   localparam logic [g_num_irqs-1:0] EDGE_MASK = g_irq_edge_mask[g_num_irqs-1:0];

   logic                  mstatus_mie;
   logic                  mstatus_mpie;
   logic                  mie_timer;
   logic [g_num_irqs-1:0] mie_lines;
   logic                  mip_timer;
   logic [g_num_irqs-1:0] mip_lines;
   logic [g_num_irqs-1:0] irq_d;
   logic [31:0]           mepc;
   logic                  mcause_irq;
   logic [4:0]            mcause_code;
   logic                  irq_req;
   logic [4:0]            irq_cause;

   logic                  csr_wr;
   logic                  wr_mstatus;
   logic                  wr_mie;
   logic                  wr_mepc;
   logic                  wr_mcause;
   logic                  wr_mip;
   logic                  mret;
   logic                  ack;
   logic                  trap;
   logic [g_num_irqs-1:0] line_rise;
   logic [g_num_irqs-1:0] line_clr;
   logic [g_num_irqs-1:0] mip_lines_next;
   logic [31:0]           mie_vec;
   logic [31:0]           mip_vec;
   logic [31:0]           pend;
   logic [4:0]            sel_cause;

   assign csr_wr     = d_is_csr_i & ~x_stall_i & ~x_kill_i;
   assign wr_mstatus = csr_wr & (d_csr_sel_i == CSR_MSTATUS);
   assign wr_mie     = csr_wr & (d_csr_sel_i == CSR_MIE);
   assign wr_mepc    = csr_wr & (d_csr_sel_i == CSR_MEPC);
   assign wr_mcause  = csr_wr & (d_csr_sel_i == CSR_MCAUSE);
   assign wr_mip     = csr_wr & (d_csr_sel_i == CSR_MIP);
   assign mret       = d_is_mret_i & ~x_stall_i & ~x_kill_i;

   // A synchronous exception in the same cycle discards the ack entirely.
   assign ack  = x_trap_ack_i & irq_req & ~exp_sync_i;
   assign trap = exp_sync_i | ack;

   // Edge lines latch a rising edge and only clear on a 0 write; level lines mirror irq_i.
   assign line_rise      = irq_i & ~irq_d & EDGE_MASK;
   assign line_clr       = wr_mip ? ~x_csr_write_value_i[16 +: g_num_irqs] : '0;
   assign mip_lines_next = (EDGE_MASK & (line_rise | (mip_lines & ~line_clr))) | (~EDGE_MASK & irq_i);

   // Assemble the architectural mie/mip views and the enabled-pending vector.
   always_comb begin
      mie_vec                   = '0;
      mip_vec                   = '0;
      mie_vec[7]                = mie_timer;
      mip_vec[7]                = mip_timer;
      mie_vec[16 +: g_num_irqs] = mie_lines;
      mip_vec[16 +: g_num_irqs] = mip_lines;
      pend                      = mip_vec & mie_vec;
   end

   // Fixed priority: timer first, then the lowest-numbered external line.
   always_comb begin
      sel_cause = 5'd7;
      if (!pend[7]) begin
         sel_cause = 5'd16;
         for (int k = g_num_irqs - 1; k >= 0; k--) begin
            if (pend[16 + k]) sel_cause = 5'(16 + k);
         end
      end
   end

   // Pending bits and the edge-detect history.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         irq_d     <= '0;
         mip_timer <= 1'b0;
         mip_lines <= '0;
      end else begin
         irq_d     <= irq_i;
         mip_lines <= mip_lines_next;
         if (exp_tick_i)
            mip_timer <= 1'b1;
         else if (wr_mip && !x_csr_write_value_i[7])
            mip_timer <= 1'b0;
      end
   end

   // Interrupt enable register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mie_timer <= 1'b0;
         mie_lines <= '0;
      end else if (wr_mie) begin
         mie_timer <= x_csr_write_value_i[7];
         mie_lines <= x_csr_write_value_i[16 +: g_num_irqs];
      end
   end

   // mstatus/mepc/mcause: trap entry beats mret, which beats a CSR write.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mepc         <= '0;
         mcause_irq   <= 1'b0;
         mcause_code  <= '0;
      end else if (trap) begin
         mepc         <= x_exception_pc_i;
         mcause_irq   <= ack;
         mcause_code  <= ack ? irq_cause : {1'b0, exp_sync_cause_i};
         mstatus_mpie <= mstatus_mie;
         mstatus_mie  <= 1'b0;
      end else begin
         if (mret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
         end else if (wr_mstatus) begin
            mstatus_mie  <= x_csr_write_value_i[3];
            mstatus_mpie <= x_csr_write_value_i[7];
         end
         if (wr_mepc)
            mepc <= x_csr_write_value_i;
         if (wr_mcause) begin
            mcause_irq  <= x_csr_write_value_i[31];
            mcause_code <= x_csr_write_value_i[4:0];
         end
      end
   end

   // Registered trap request; cause stays frozen until ack or retraction.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         irq_req   <= 1'b0;
         irq_cause <= '0;
      end else if (ack) begin
         irq_req <= 1'b0;
      end else if (irq_req) begin
         if (!mstatus_mie || !pend[irq_cause])
            irq_req <= 1'b0;
      end else if (mstatus_mie && (|pend)) begin
         irq_req   <= 1'b1;
         irq_cause <= sel_cause;
      end
   end

   assign irq_req_o        = irq_req;
   assign irq_cause_o      = irq_cause;
   assign x_exception_pc_o = mepc;
   assign csr_mstatus_o    = {24'h0, mstatus_mpie, 3'b000, mstatus_mie, 3'b000};
   assign csr_mie_o        = mie_vec;
   assign csr_mip_o        = mip_vec;
   assign csr_mepc_o       = mepc;
   assign csr_mcause_o     = {mcause_irq, 26'h0, mcause_code};

endmodule

// File: tb/tb_urv_irq_ctrl.sv
// tb/tb_urv_irq_ctrl.sv - directed scoreboard bench for urv_irq_ctrl
module tb_urv_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        x_stall_i;
   logic        x_kill_i;
   logic        d_is_csr_i;
   logic        d_is_mret_i;
   logic [11:0] d_csr_sel_i;
   logic [31:0] x_csr_write_value_i;
   logic [3:0]  irq_i;
   logic        exp_tick_i;
   logic        exp_sync_i;
   logic [3:0]  exp_sync_cause_i;
   logic [31:0] x_exception_pc_i;
   logic        x_trap_ack_i;
   logic        irq_req_o;
   logic [4:0]  irq_cause_o;
   logic [31:0] x_exception_pc_o;
   logic [31:0] csr_mstatus_o;
   logic [31:0] csr_mie_o;
   logic [31:0] csr_mip_o;
   logic [31:0] csr_mepc_o;
   logic [31:0] csr_mcause_o;

   always #5 clk = ~clk;

   urv_irq_ctrl #(
      .g_num_irqs      (4),
      .g_irq_edge_mask (16'h0001)
   ) dut (
      .clk_i               (clk),
      .rst_i               (rst_i),
      .x_stall_i           (x_stall_i),
      .x_kill_i            (x_kill_i),
      .d_is_csr_i          (d_is_csr_i),
      .d_is_mret_i         (d_is_mret_i),
      .d_csr_sel_i         (d_csr_sel_i),
      .x_csr_write_value_i (x_csr_write_value_i),
      .irq_i               (irq_i),
      .exp_tick_i          (exp_tick_i),
      .exp_sync_i          (exp_sync_i),
      .exp_sync_cause_i    (exp_sync_cause_i),
      .x_exception_pc_i    (x_exception_pc_i),
      .x_trap_ack_i        (x_trap_ack_i),
      .irq_req_o           (irq_req_o),
      .irq_cause_o         (irq_cause_o),
      .x_exception_pc_o    (x_exception_pc_o),
      .csr_mstatus_o       (csr_mstatus_o),
      .csr_mie_o           (csr_mie_o),
      .csr_mip_o           (csr_mip_o),
      .csr_mepc_o          (csr_mepc_o),
      .csr_mcause_o        (csr_mcause_o)
   );

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic push_exp(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic observe(input logic [31:0] obs);
      exp_t e;
      n_tests++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=%08h expected=none", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_write(input logic [11:0] sel, input logic [31:0] val);
      d_is_csr_i          = 1'b1;
      d_csr_sel_i         = sel;
      x_csr_write_value_i = val;
      tick();
      d_is_csr_i          = 1'b0;
   endtask

   task automatic check_req(input string tag, input logic req, input logic [4:0] cause);
      push_exp({tag, "_req"}, {31'h0, req});
      if (req) push_exp({tag, "_cause"}, {27'h0, cause});
      observe({31'h0, irq_req_o});
      if (req) observe({27'h0, irq_cause_o});
   endtask

   task automatic check_all_zero(input string tag);
      push_exp({tag, "_req"}, 32'h0);
      push_exp({tag, "_mstatus"}, 32'h0);
      push_exp({tag, "_mie"}, 32'h0);
      push_exp({tag, "_mip"}, 32'h0);
      push_exp({tag, "_mepc"}, 32'h0);
      push_exp({tag, "_mcause"}, 32'h0);
      observe({31'h0, irq_req_o});
      observe(csr_mstatus_o);
      observe(csr_mie_o);
      observe(csr_mip_o);
      observe(csr_mepc_o);
      observe(csr_mcause_o);
   endtask

   initial begin
      rst_i               = 1'b1;
      x_stall_i           = 1'b0;
      x_kill_i            = 1'b0;
      d_is_csr_i          = 1'b0;
      d_is_mret_i         = 1'b0;
      d_csr_sel_i         = 12'h0;
      x_csr_write_value_i = 32'h0;
      irq_i               = 4'h0;
      exp_tick_i          = 1'b0;
      exp_sync_i          = 1'b0;
      exp_sync_cause_i    = 4'h0;
      x_exception_pc_i    = 32'h0;
      x_trap_ack_i        = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;

      // reset state
      check_all_zero("reset");

      // edge line 0
      csr_write(12'h304, 32'h0001_0000);
      csr_write(12'h300, 32'h0000_0008);
      irq_i = 4'b0001;
      tick();
      irq_i = 4'b0000;
      push_exp("edge_mip", 32'h0001_0000);
      observe(csr_mip_o);
      check_req("edge_early", 1'b0, 5'd0);
      tick();
      check_req("edge_raise", 1'b1, 5'd16);

      // acknowledge
      x_exception_pc_i = 32'h0000_0100;
      x_trap_ack_i     = 1'b1;
      tick();
      x_trap_ack_i     = 1'b0;
      push_exp("ack_mepc", 32'h0000_0100);
      push_exp("ack_mcause", 32'h8000_0010);
      push_exp("ack_mstatus", 32'h0000_0080);
      push_exp("ack_xpc", 32'h0000_0100);
      observe(csr_mepc_o);
      observe(csr_mcause_o);
      observe(csr_mstatus_o);
      observe(x_exception_pc_o);
      check_req("ack_req", 1'b0, 5'd0);

      // masked: line 0 still pending but MIE=0
      tick();
      tick();
      push_exp("masked_mip", 32'h0001_0000);
      observe(csr_mip_o);
      check_req("masked", 1'b0, 5'd0);

      // mret restores MIE; request re-raises the following cycle
      d_is_mret_i = 1'b1;
      tick();
      d_is_mret_i = 1'b0;
      push_exp("mret_mstatus", 32'h0000_0088);
      observe(csr_mstatus_o);
      tick();
      check_req("mret_reraise", 1'b1, 5'd16);

      // take it again, then clear the edge latch
      x_exception_pc_i = 32'h0000_0104;
      x_trap_ack_i     = 1'b1;
      tick();
      x_trap_ack_i     = 1'b0;
      csr_write(12'h344, 32'h0000_0000);
      push_exp("edge_clear_mip", 32'h0000_0000);
      observe(csr_mip_o);

      // priority: timer, level line 1, level line 2
      csr_write(12'h304, 32'h0006_0080);
      irq_i      = 4'b0110;
      exp_tick_i = 1'b1;
      tick();
      exp_tick_i = 1'b0;
      csr_write(12'h300, 32'h0000_0008);
      tick();
      push_exp("prio_mip", 32'h0006_0080);
      observe(csr_mip_o);
      check_req("prio_timer", 1'b1, 5'd7);
      csr_write(12'h344, 32'hFFFF_FF7F);
      tick();
      check_req("prio_retract", 1'b0, 5'd0);
      tick();
      check_req("prio_line1", 1'b1, 5'd17);

      // level line 1 drops while pending unacked
      irq_i = 4'b0100;
      tick();
      push_exp("lvl_drop_mip", 32'h0004_0000);
      observe(csr_mip_o);
      tick();
      check_req("lvl_retract", 1'b0, 5'd0);
      tick();
      check_req("prio_line2", 1'b1, 5'd18);

      // level bits ignore mip writes
      irq_i = 4'b0110;
      tick();
      csr_write(12'h344, 32'h0000_0000);
      push_exp("lvl_write_mip", 32'h0006_0000);
      observe(csr_mip_o);
      check_req("lvl_write_hold", 1'b1, 5'd18);

      // sync exception and ack in the same cycle
      exp_sync_i       = 1'b1;
      exp_sync_cause_i = 4'd2;
      x_trap_ack_i     = 1'b1;
      x_exception_pc_i = 32'h0000_0200;
      tick();
      exp_sync_i       = 1'b0;
      x_trap_ack_i     = 1'b0;
      push_exp("sync_mcause", 32'h0000_0002);
      push_exp("sync_mepc", 32'h0000_0200);
      push_exp("sync_mstatus", 32'h0000_0080);
      observe(csr_mcause_o);
      observe(csr_mepc_o);
      observe(csr_mstatus_o);
      tick();
      check_req("sync_req_drop", 1'b0, 5'd0);

      // stalled CSR write does nothing
      x_stall_i = 1'b1;
      csr_write(12'h341, 32'h0000_DEAD);
      x_stall_i = 1'b0;
      push_exp("stall_mepc", 32'h0000_0200);
      observe(csr_mepc_o);

      // async reset in the middle of a request
      csr_write(12'h300, 32'h0000_0008);
      tick();
      check_req("pre_reset", 1'b1, 5'd17);
      #2 rst_i = 1'b1;
      #1;
      check_all_zero("async_reset");
      irq_i = 4'b0000;
      tick();
      rst_i = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
